// File: rtl/bank_isu_credit_ctrl.sv
// Per-channel read-credit controller for the bank issue queue: grants credits to
// entries at enqueue or later, oldest-first from the queue bottom pointer.
module bank_isu_credit_ctrl #(
  parameter int CHANNEL_NUM        = 4,
  parameter int CH_ID_WIDTH        = 2,
  parameter int PTR_WIDTH          = 4,
  parameter int DEPTH              = 1 << PTR_WIDTH,
  parameter int CREDIT_MAX         = 8,
  parameter int CREDIT_WIDTH       = 4,
  parameter int WRITE_NEEDS_CREDIT = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 iq_enqueue,
  input  logic [PTR_WIDTH-1:0]                 iq_write_ptr,
  input  logic                                 htu_op_is_read,
  input  logic [CH_ID_WIDTH-1:0]               htu_ch_id,
  input  logic [PTR_WIDTH-1:0]                 iq_bottom_ptr,
  input  logic [DEPTH-1:0]                     iq_valid_array,
  input  logic [DEPTH*CH_ID_WIDTH-1:0]         ch_id_array,
  input  logic                                 iq_dequeue,
  input  logic [PTR_WIDTH-1:0]                 iq_dequeue_ptr,
  input  logic                                 iq_flush,
  input  logic [PTR_WIDTH-1:0]                 iq_flush_ptr,
  input  logic [CHANNEL_NUM-1:0]               channels_credit_release,
  output logic [DEPTH-1:0]                     credit_allow_array,
  output logic [CHANNEL_NUM*CREDIT_WIDTH-1:0]  channels_credit_num,
  output logic [CHANNEL_NUM*(PTR_WIDTH+1)-1:0] channels_pending_num,
  output logic                                 credit_err
);

  localparam int PW  = PTR_WIDTH + 1;
  localparam int CW2 = CREDIT_WIDTH + 2;
  localparam int PW2 = PTR_WIDTH + 3;

  logic [DEPTH-1:0]        allow_q, allow_d, need_q, need_d;
  logic [CREDIT_WIDTH-1:0] credit_q  [CHANNEL_NUM];
  logic [CREDIT_WIDTH-1:0] credit_d  [CHANNEL_NUM];
  logic [PW-1:0]           pending_q [CHANNEL_NUM];
  logic [PW-1:0]           pending_d [CHANNEL_NUM];
  logic                    err_q, err_d;

  logic [CHANNEL_NUM-1:0]  pgnt;
  logic [PTR_WIDTH-1:0]    pgnt_idx [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0]  grant_err;
  logic                    need_in, direct_any;
  logic [CH_ID_WIDTH-1:0]  fl_ch;

  assign need_in = htu_op_is_read | (WRITE_NEEDS_CREDIT != 0);
  assign fl_ch   = ch_id_array[int'(iq_flush_ptr)*CH_ID_WIDTH +: CH_ID_WIDTH];

  // Pending grant search, driven only by registered state so an entry enqueued
  // this cycle can never be picked before its need bit is stored.
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      logic                 want, found;
      logic [PTR_WIDTH-1:0] p;
      want        = (credit_q[c] != '0) && (pending_q[c] != '0);
      found       = 1'b0;
      pgnt_idx[c] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        p = iq_bottom_ptr + PTR_WIDTH'(k);
        if (!found && iq_valid_array[p] && need_q[p] && !allow_q[p] &&
            ch_id_array[int'(p)*CH_ID_WIDTH +: CH_ID_WIDTH] == CH_ID_WIDTH'(c) &&
            !(iq_flush && iq_flush_ptr == p)) begin
          found       = 1'b1;
          pgnt_idx[c] = p;
        end
      end
      pgnt[c]      = want && found;
      grant_err[c] = want && !found;
    end
  end

  // Counter arithmetic: every event for a channel nets in a single sum.
  always_comb begin
    err_d      = err_q | (|grant_err);
    direct_any = 1'b0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      logic           enq_hit, direct, enq_pend, fl_ret, fl_pend;
      logic [CW2-1:0] csum;
      logic [PW2-1:0] padd, psub;
      enq_hit  = iq_enqueue && need_in && (htu_ch_id == CH_ID_WIDTH'(c));
      direct   = enq_hit && (credit_q[c] != '0) && (pending_q[c] == '0);
      enq_pend = enq_hit && !direct;
      fl_ret   = iq_flush && need_q[iq_flush_ptr] && allow_q[iq_flush_ptr] &&
                 (fl_ch == CH_ID_WIDTH'(c));
      fl_pend  = iq_flush && need_q[iq_flush_ptr] && !allow_q[iq_flush_ptr] &&
                 (fl_ch == CH_ID_WIDTH'(c));
      direct_any = direct_any | direct;

      csum = CW2'(credit_q[c]) - CW2'(pgnt[c] | direct) +
             CW2'(channels_credit_release[c]) + CW2'(fl_ret);
      if (csum > CW2'(CREDIT_MAX)) begin
        credit_d[c] = CREDIT_WIDTH'(CREDIT_MAX);
        err_d       = 1'b1;
      end else begin
        credit_d[c] = csum[CREDIT_WIDTH-1:0];
      end

      padd = PW2'(pending_q[c]) + PW2'(enq_pend);
      psub = PW2'(pgnt[c]) + PW2'(fl_pend);
      if (psub > padd) begin
        pending_d[c] = '0;
        err_d        = 1'b1;
      end else begin
        pending_d[c] = PW'(padd - psub);
      end
    end
  end

  // Entry bits: grant set < enqueue write < dequeue/flush clear.
  always_comb begin
    allow_d = allow_q;
    need_d  = need_q;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (pgnt[c]) allow_d[pgnt_idx[c]] = 1'b1;
    end
    if (iq_enqueue) begin
      allow_d[iq_write_ptr] = !need_in || direct_any;
      need_d[iq_write_ptr]  = need_in;
    end
    if (iq_dequeue) begin
      allow_d[iq_dequeue_ptr] = 1'b0;
      need_d[iq_dequeue_ptr]  = 1'b0;
    end
    if (iq_flush) begin
      allow_d[iq_flush_ptr] = 1'b0;
      need_d[iq_flush_ptr]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      allow_q <= '0;
      need_q  <= '0;
      err_q   <= 1'b0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        credit_q[c]  <= CREDIT_WIDTH'(CREDIT_MAX);
        pending_q[c] <= '0;
      end
    end else begin
      allow_q <= allow_d;
      need_q  <= need_d;
      err_q   <= err_d;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        credit_q[c]  <= credit_d[c];
        pending_q[c] <= pending_d[c];
      end
    end
  end

  assign credit_allow_array = allow_q;
  assign credit_err         = err_q;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_pack
    assign channels_credit_num[c*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[c];
    assign channels_pending_num[c*PW +: PW]                    = pending_q[c];
  end

endmodule

// File: tb/tb_bank_isu_credit_ctrl.sv
// Directed bench for bank_isu_credit_ctrl: hand-computed credits, pending counts,
// allow bits and error flag across grant, wrap, flush and saturation cases.
module tb_bank_isu_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iq_enqueue;
  logic [3:0]  iq_write_ptr;
  logic        htu_op_is_read;
  logic [1:0]  htu_ch_id;
  logic [3:0]  iq_bottom_ptr;
  logic [15:0] iq_valid_array;
  logic [31:0] ch_id_array;
  logic        iq_dequeue;
  logic [3:0]  iq_dequeue_ptr;
  logic        iq_flush;
  logic [3:0]  iq_flush_ptr;
  logic [3:0]  channels_credit_release;

  logic [15:0] allow, allow_w;
  logic [15:0] credit_num, credit_num_w;
  logic [19:0] pending_num, pending_num_w;
  logic        err, err_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bank_isu_credit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .iq_enqueue(iq_enqueue), .iq_write_ptr(iq_write_ptr),
    .htu_op_is_read(htu_op_is_read), .htu_ch_id(htu_ch_id), .iq_bottom_ptr(iq_bottom_ptr),
    .iq_valid_array(iq_valid_array), .ch_id_array(ch_id_array), .iq_dequeue(iq_dequeue),
    .iq_dequeue_ptr(iq_dequeue_ptr), .iq_flush(iq_flush), .iq_flush_ptr(iq_flush_ptr),
    .channels_credit_release(channels_credit_release), .credit_allow_array(allow),
    .channels_credit_num(credit_num), .channels_pending_num(pending_num), .credit_err(err)
  );

  bank_isu_credit_ctrl #(.WRITE_NEEDS_CREDIT(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .iq_enqueue(iq_enqueue), .iq_write_ptr(iq_write_ptr),
    .htu_op_is_read(htu_op_is_read), .htu_ch_id(htu_ch_id), .iq_bottom_ptr(iq_bottom_ptr),
    .iq_valid_array(iq_valid_array), .ch_id_array(ch_id_array), .iq_dequeue(iq_dequeue),
    .iq_dequeue_ptr(iq_dequeue_ptr), .iq_flush(iq_flush), .iq_flush_ptr(iq_flush_ptr),
    .channels_credit_release(channels_credit_release), .credit_allow_array(allow_w),
    .channels_credit_num(credit_num_w), .channels_pending_num(pending_num_w), .credit_err(err_w)
  );

  function automatic logic [31:0] cr(input int c);
    return 32'(credit_num[c*4 +: 4]);
  endfunction

  function automatic logic [31:0] pd(input int c);
    return 32'(pending_num[c*5 +: 5]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] p, input logic rd, input logic [1:0] ch);
    iq_enqueue     = 1'b1;
    iq_write_ptr   = p;
    htu_op_is_read = rd;
    htu_ch_id      = ch;
    iq_valid_array[p]    = 1'b1;
    ch_id_array[p*2 +: 2] = ch;
    tick();
    iq_enqueue = 1'b0;
  endtask

  task automatic deq(input logic [3:0] p);
    iq_dequeue     = 1'b1;
    iq_dequeue_ptr = p;
    tick();
    iq_dequeue = 1'b0;
    iq_valid_array[p] = 1'b0;
  endtask

  task automatic rel(input logic [3:0] mask);
    channels_credit_release = mask;
    tick();
    channels_credit_release = '0;
  endtask

  task automatic flush(input logic [3:0] p);
    iq_flush     = 1'b1;
    iq_flush_ptr = p;
    tick();
    iq_flush = 1'b0;
    iq_valid_array[p] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iq_enqueue = 1'b0; iq_write_ptr = '0; htu_op_is_read = 1'b0; htu_ch_id = '0;
    iq_bottom_ptr = '0; iq_valid_array = '0; ch_id_array = '0;
    iq_dequeue = 1'b0; iq_dequeue_ptr = '0; iq_flush = 1'b0; iq_flush_ptr = '0;
    channels_credit_release = '0;
    repeat (2) tick();

    chk("rst_allow", 32'(allow), 32'h0);
    chk("rst_credit", 32'(credit_num), 32'h8888);
    chk("rst_pending", 32'(pending_num), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Write enqueue: free without write credits, charged with them.
    enq(4'd5, 1'b0, 2'd2);
    chk("wr_allow", 32'(allow[5]), 32'h1);
    chk("wr_credit2", cr(2), 32'd8);
    chk("wr_allow_w", 32'(allow_w[5]), 32'h1);
    chk("wr_credit2_w", 32'(credit_num_w[8 +: 4]), 32'd7);
    deq(4'd5);

    // Single read on ch1.
    enq(4'd3, 1'b1, 2'd1);
    chk("rd_allow3", 32'(allow[3]), 32'h1);
    chk("rd_credit1", cr(1), 32'd7);
    chk("rd_pending1", pd(1), 32'd0);
    deq(4'd3);
    rel(4'b0010);
    chk("rd_credit1_back", cr(1), 32'd8);

    // Wrap order: drain ch2, then pending entries at 1, 15, 0 with bottom 14.
    for (int i = 4; i < 12; i++) enq(4'(i), 1'b1, 2'd2);
    chk("wrap_credit2_drained", cr(2), 32'd0);
    enq(4'd1, 1'b1, 2'd2);
    enq(4'd15, 1'b1, 2'd2);
    enq(4'd0, 1'b1, 2'd2);
    iq_bottom_ptr = 4'd14;
    chk("wrap_pending2", pd(2), 32'd3);
    chk("wrap_none", 32'({allow[1], allow[0], allow[15]}), 32'b000);
    channels_credit_release = 4'b0100;
    tick();
    chk("wrap_t1_credit", cr(2), 32'd1);
    chk("wrap_t1_allow", 32'({allow[1], allow[0], allow[15]}), 32'b000);
    tick();
    chk("wrap_t2_allow", 32'({allow[1], allow[0], allow[15]}), 32'b001);
    tick();
    channels_credit_release = '0;
    chk("wrap_t3_allow", 32'({allow[1], allow[0], allow[15]}), 32'b011);
    tick();
    chk("wrap_t4_allow", 32'({allow[1], allow[0], allow[15]}), 32'b111);
    chk("wrap_t4_credit", cr(2), 32'd0);
    chk("wrap_t4_pending", pd(2), 32'd0);
    for (int i = 4; i < 12; i++) deq(4'(i));
    deq(4'd1);
    deq(4'd15);
    deq(4'd0);
    iq_bottom_ptr = 4'd0;

    // Nine reads on ch0: eight direct grants, the ninth waits.
    for (int i = 0; i < 9; i++) enq(4'(i), 1'b1, 2'd0);
    chk("nine_allow", 32'(allow[8:0]), 32'h0FF);
    chk("nine_credit0", cr(0), 32'd0);
    chk("nine_pending0", pd(0), 32'd1);
    rel(4'b0001);
    chk("rel_credit0", cr(0), 32'd1);
    chk("rel_allow8", 32'(allow[8]), 32'h0);
    tick();
    chk("gnt_allow8", 32'(allow[8]), 32'h1);
    chk("gnt_credit0", cr(0), 32'd0);
    chk("gnt_pending0", pd(0), 32'd0);

    // Flush of a granted read returns its credit.
    flush(4'd2);
    chk("fl_gnt_credit0", cr(0), 32'd1);
    chk("fl_gnt_allow2", 32'(allow[2]), 32'h0);
    enq(4'd9, 1'b1, 2'd0);
    chk("reuse_allow9", 32'(allow[9]), 32'h1);
    chk("reuse_credit0", cr(0), 32'd0);

    // Flush of a pending read drops the pending count and never grants it.
    enq(4'd10, 1'b1, 2'd0);
    chk("pend10_pending0", pd(0), 32'd1);
    chk("pend10_allow", 32'(allow[10]), 32'h0);
    flush(4'd10);
    chk("fl_pend_pending0", pd(0), 32'd0);
    chk("fl_pend_allow10", 32'(allow[10]), 32'h0);
    chk("fl_pend_credit0", cr(0), 32'd0);
    chk("fl_pend_err", 32'(err), 32'h0);

    // Release, pending grant and flush return in one cycle: net +1.
    enq(4'd11, 1'b1, 2'd0);
    rel(4'b0001);
    chk("mix_pre_credit0", cr(0), 32'd1);
    chk("mix_pre_pending0", pd(0), 32'd1);
    channels_credit_release = 4'b0001;
    flush(4'd0);
    channels_credit_release = '0;
    chk("mix_credit0", cr(0), 32'd2);
    chk("mix_pending0", pd(0), 32'd0);
    chk("mix_allow11", 32'(allow[11]), 32'h1);
    chk("mix_allow0", 32'(allow[0]), 32'h0);
    chk("mix_err", 32'(err), 32'h0);

    // Over-release saturates and sets the sticky error.
    rel(4'b1000);
    chk("sat_credit3", cr(3), 32'd8);
    chk("sat_err", 32'(err), 32'h1);
    repeat (3) tick();
    chk("sat_err_sticky", 32'(err), 32'h1);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_allow", 32'(allow), 32'h0);
    chk("arst_credit", 32'(credit_num), 32'h8888);
    chk("arst_pending", 32'(pending_num), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
